// File: rtl/div_pkg.sv
// Shared divider constants and helpers, also used by the future fractional divider.
package div_pkg;

   localparam int unsigned DIV_MIN = 2;

   // First phase at which the divided clock is high: gives floor(n/2) high cycles.
   function automatic int unsigned hi_start(input int unsigned n);
      return n - (n >> 1);
   endfunction

endpackage

// File: rtl/div_clk_n.sv
// Runtime-programmable clock divider: square wave, per-period tick and phase count,
// with ratio changes applied only at period boundaries.
module div_clk_n
   import div_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int DIV_DEFAULT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CNT_W-1:0] div_ratio,
   input  logic             load,
   output logic [CNT_W-1:0] po_cnt,
   output logic             clk_out,
   output logic             tick,
   output logic [CNT_W-1:0] cur_ratio,
   output logic             ratio_ack,
   output logic             err
);

   logic [CNT_W-1:0] pend_ratio;
   logic             pend_vld;
   logic             wrap;
   logic             load_ok;
   logic             load_bad;
   logic             apply_new;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] ratio_next;
   logic [CNT_W-1:0] hi_thr;

   assign wrap     = en && (po_cnt == cur_ratio - CNT_W'(1));
   assign load_ok  = load && (div_ratio >= CNT_W'(DIV_MIN));
   assign load_bad = load && !load_ok;
   assign tick     = wrap;

   // A load arriving on the wrap edge wins over any older pending ratio.
   always_comb begin
      cnt_next   = po_cnt;
      ratio_next = cur_ratio;
      apply_new  = 1'b0;
      if (en) begin
         if (wrap) begin
            cnt_next = '0;
            if (load_ok) begin
               ratio_next = div_ratio;
               apply_new  = 1'b1;
            end else if (pend_vld) begin
               ratio_next = pend_ratio;
               apply_new  = 1'b1;
            end
         end else begin
            cnt_next = po_cnt + CNT_W'(1);
         end
      end
   end

   assign hi_thr = CNT_W'(hi_start(32'(ratio_next)));

   always_ff @(posedge clk) begin
      if (rst_n) begin
         po_cnt     <= '0;
         clk_out    <= 1'b0;
         cur_ratio  <= CNT_W'(DIV_DEFAULT);
         pend_ratio <= CNT_W'(DIV_DEFAULT);
         pend_vld   <= 1'b0;
         ratio_ack  <= 1'b0;
         err        <= 1'b0;
      end else begin
         po_cnt    <= cnt_next;
         cur_ratio <= ratio_next;
         ratio_ack <= apply_new;
         err       <= load_bad;
         if (en) begin
            clk_out <= (cnt_next >= hi_thr);
         end
         if (apply_new) begin
            pend_vld <= 1'b0;
         end else if (load_ok) begin
            pend_ratio <= div_ratio;
            pend_vld   <= 1'b1;
         end
      end
   end

endmodule

// File: doc/div_clk_n.md
# div_clk_n

Parametrised synchronous clock divider. It generalises the fixed divide-by-4 counter to a runtime-programmable ratio N (odd or even, 2..2^CNT_W-1). Ratio changes are glitch-free because they take effect only at a period boundary. It produces a divided square wave, a one-cycle tick strobe per period, and the live phase count, and it sits in the clock-enable generation path feeding slower logic in the `clk` domain.

## Interface

Parameters:
- `CNT_W`, default 8: counter and ratio width.
- `DIV_DEFAULT`, default 4: ratio loaded at reset. Must be in the range 2..2^CNT_W-1.

Ports:
- `clk`, input, 1: the single clock. Everything is on its rising edge.
- `rst_n`, input, 1: reset. It is synchronous and active-high despite the name (1 = reset).
- `en`, input, 1: run enable. When low, all state freezes.
- `div_ratio`, input, CNT_W: requested ratio N. It is sampled only when `load` = 1.
- `load`, input, 1: one-cycle request to change the ratio.
- `po_cnt`, output, CNT_W: phase counter, 0..N-1.
- `clk_out`, output, 1: divided clock, registered.
- `tick`, output, 1: high for one cycle when `po_cnt` = N-1 with `en` = 1.
- `cur_ratio`, output, CNT_W: ratio currently in effect.
- `ratio_ack`, output, 1: one-cycle pulse on the first cycle of a period that uses a new ratio.
- `err`, output, 1: one-cycle pulse when a `load` is rejected.

## Operation

- **Internal state:** `cur_ratio`, `pend_ratio`, `pend_vld`, `po_cnt`, `clk_out`.
- **Counting:** when `en` = 1, `po_cnt` increments. When `po_cnt` = `cur_ratio`-1 (the wrap), it returns to 0 on the next edge. When `en` = 0, the counter and `clk_out` hold and `tick` = 0.
- **`clk_out` waveform:** `clk_out` = 1 exactly when `po_cnt` >= N - floor(N/2). It is generated from the next-count value so that it is registered and aligned with `po_cnt`.
  - The result is high for floor(N/2) cycles and low for ceil(N/2) cycles.
  - Even N gives a 50 % duty cycle. For N = 3 the output is low for 2 cycles and high for 1.
- **`tick`:** asserted when `po_cnt` = `cur_ratio`-1 and `en` = 1, coincident with the last cycle of the period.
- **Load acceptance:** `load` with `div_ratio` >= 2 is accepted. The value goes to `pend_ratio` and `pend_vld` is set to 1. A newer accepted load overwrites an older pending value (last one wins).
- **Load rejection:** `load` with `div_ratio` of 0 or 1 is rejected. `err` = 1 on the next cycle, and any pending value is untouched.
- **Applying a pending ratio:** at a wrap edge with `pend_vld` = 1:
  - `cur_ratio` takes `pend_ratio`;
  - `pend_vld` clears;
  - `po_cnt` goes to 0;
  - `ratio_ack` = 1 for that first cycle of the new period.
- **Load coinciding with a wrap:** if an accepted `load` arrives on the same edge as a wrap, the new value is applied at that wrap, bypassing the pending register.
- **Disabled loads:** loads accepted while `en` = 0 stay pending until the next wrap after `en` returns high.
- **`cur_ratio` stability:** `cur_ratio` never changes mid-period.
- **Reset:** reset overrides every other input, including `en`, and can be applied at any phase.

## Timing

- **Reset values** (applied on the edge where `rst_n` = 1):

  | Output / state | Value |
  |---|---|
  | `po_cnt` | 0 |
  | `clk_out` | 0 |
  | `tick` | 0 |
  | `ratio_ack` | 0 |
  | `err` | 0 |
  | `cur_ratio` | `DIV_DEFAULT` |
  | `pend_vld` | 0 |

- **Latency after reset release:** `po_cnt` = 1 on the first edge with `en` = 1.
- **Period:** `tick` has period exactly `cur_ratio` enabled cycles.
- **Ratio change latency:**
  - The new ratio takes effect at the first wrap at or after the load edge.
  - Worst-case latency is old N enabled cycles.
  - There is never a runt high or low pulse on `clk_out`.
- **`err` timing:** `err` is registered one cycle after the rejected `load`.
- **Arithmetic:** all compares are unsigned and CNT_W wide. `cur_ratio`-1 never underflows because `cur_ratio` >= 2 always holds.

## Structure

- **Shared package:** `div_pkg` holds `DIV_MIN` = 2 and the `clk_out` threshold function `hi_start(n)` = n - (n>>1). Both are shared with the future fractional divider.
- **Sub-modules:** a single flat module. The ratio-load logic is too small to be a separate sub-module.

## Test plan

1. Reset with default parameters, then `en` = 1:
   - `po_cnt` cycles 0,1,2,3;
   - `clk_out` is 0,0,1,1;
   - `tick` is high at `po_cnt` = 3 every 4 cycles.
2. With N = 4, load 5 at `po_cnt` = 1:
   - the current period completes with 4 counts;
   - `ratio_ack` pulses at the next `po_cnt` = 0;
   - `cur_ratio` = 5;
   - `clk_out` is 0,0,0,1,1 per period.
3. Load 1, and separately load 0:
   - `err` pulses once for each;
   - `cur_ratio` and the pending value are unchanged.
4. Load 6 then load 3 within the same period, followed by a load 7 on the exact wrap edge:
   - 7 is applied at that wrap;
   - 3 and 6 are never used.
5. Drop `en` for 10 cycles at `po_cnt` = 2:
   - `po_cnt`, `clk_out` and `cur_ratio` hold;
   - `tick` stays 0;
   - counting resumes from 3.
6. Set N = 255 (CNT_W = 8) and assert reset mid-period at `po_cnt` = 200:
   - before the reset, `tick` occurs at `po_cnt` = 254;
   - the reset returns all outputs to their reset values and restores `cur_ratio` to 4.
